// File: rtl/mat_pkg.sv
// Shared types for the matrix frame buffer, the scan driver and their benches.
package mat_pkg;
  localparam int MAT_ROWS = 8;
  localparam int MAT_COLS = 8;

  typedef logic [$clog2(MAT_ROWS)-1:0] row_idx_t;
  typedef logic [MAT_COLS-1:0]         row_data_t;

  typedef enum logic {FB_IDLE, FB_PENDING} fb_state_t;
endpackage

// File: rtl/mat_fb_bank.sv
// One ROWS x COLS bitmap bank: synchronous write and clear, combinational read.
module mat_fb_bank #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    we,
  input  logic [$clog2(ROWS)-1:0] waddr,
  input  logic [COLS-1:0]         wdata,
  input  logic [$clog2(ROWS)-1:0] raddr,
  output logic [COLS-1:0]         rdata
);
  logic [COLS-1:0] mem [ROWS];

  // Out-of-range rows are silently dropped on write and read back as zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < ROWS; i++) mem[i] <= '0;
    end else if (we && (int'(waddr) < ROWS)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (int'(raddr) < ROWS) ? mem[raddr] : '0;
endmodule

// File: rtl/mat_frame_buf.sv
// Double-buffered 8x8 bitmap store feeding the matrix scan driver; swaps only on frame_start.
// Optional column scrolling is enabled with `define MAT_FB_SCROLL_EN.
module mat_frame_buf
  import mat_pkg::*;
#(
  parameter int ROWS          = MAT_ROWS,
  parameter int COLS          = MAT_COLS,
  parameter int CLEAR_ON_SWAP = 0,
  parameter int SCROLL_DIV    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  input  logic                    swap_req,
  output logic                    swap_ack,
  input  logic                    frame_start,
  input  logic                    rd_en,
  input  logic [$clog2(ROWS)-1:0] rd_row,
  output logic [COLS-1:0]         rd_data
);
  fb_state_t       state;
  logic            front_sel;
  logic            swap_go;
  logic            wr_fire;
  logic [COLS-1:0] rd0, rd1, front_row, rd_next;

  assign swap_go = (state == FB_PENDING) && frame_start;
  assign wr_fire = wr_valid && wr_ready;

  // Bank b is the back buffer when front_sel != b; the front bank is the one cleared on swap.
  mat_fb_bank #(.ROWS(ROWS), .COLS(COLS)) u_bank0 (
    .clk(clk), .rst(rst),
    .clr((CLEAR_ON_SWAP != 0) && swap_go && !front_sel),
    .we(wr_fire && front_sel), .waddr(wr_row), .wdata(wr_data),
    .raddr(rd_row), .rdata(rd0)
  );

  mat_fb_bank #(.ROWS(ROWS), .COLS(COLS)) u_bank1 (
    .clk(clk), .rst(rst),
    .clr((CLEAR_ON_SWAP != 0) && swap_go && front_sel),
    .we(wr_fire && !front_sel), .waddr(wr_row), .wdata(wr_data),
    .raddr(rd_row), .rdata(rd1)
  );

  assign front_row = front_sel ? rd1 : rd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FB_IDLE;
      front_sel <= 1'b0;
      wr_ready  <= 1'b0;
      swap_ack  <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (state)
        FB_IDLE: begin
          wr_ready <= !swap_req;
          if (swap_req) state <= FB_PENDING;
        end
        FB_PENDING: begin
          // Back buffer stays frozen until the scan driver reaches row 0.
          if (frame_start) begin
            front_sel <= !front_sel;
            swap_ack  <= 1'b1;
            wr_ready  <= 1'b1;
            state     <= FB_IDLE;
          end
        end
        default: begin
          state    <= FB_IDLE;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef MAT_FB_SCROLL_EN
  localparam int FCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  logic [FCW-1:0]           fcnt;
  logic [$clog2(COLS)-1:0]  offset;
  logic [2*COLS-1:0]        dbl;

  always_ff @(posedge clk) begin
    if (rst || swap_go) begin
      fcnt   <= '0;
      offset <= '0;
    end else if (frame_start) begin
      if (int'(fcnt) >= SCROLL_DIV - 1) begin
        fcnt   <= '0;
        offset <= (int'(offset) == COLS - 1) ? '0 : offset + 1'b1;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Rotate left: the upper half of the doubled row shifted by offset.
  assign dbl     = {front_row, front_row} << offset;
  assign rd_next = dbl[2*COLS-1:COLS];
`else
  assign rd_next = front_row;
`endif

  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= rd_next;
  end
endmodule

// File: doc/mat_frame_buf.md
Name: mat_frame_buf

Overview:
- Double-buffered 8x8 bitmap store that sits directly upstream of the matrix scan driver.
- The scan driver reads one row of column data per scan slot and pulses frame_start at row 0.
- A host/pattern source writes rows into the back buffer.
- Buffers swap only on a frame boundary, so a displayed frame never tears.

Parameters:
- ROWS, 8, number of matrix rows; row index width is $clog2(ROWS).
- COLS, 8, column bits per row; width of all row data.
- CLEAR_ON_SWAP, 0, when 1 the new back buffer is zeroed in the swap cycle.
- SCROLL_DIV, 4, frames per one-column scroll step; used only with MAT_FB_SCROLL_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- wr_valid  in  1  write request.
- wr_ready  out  1  back buffer accepting writes.
- wr_row  in  $clog2(ROWS)  target row in back buffer.
- wr_data  in  COLS  row bitmap to write.
- swap_req  in  1  request front/back exchange (level sampled, one cycle used).
- swap_ack  out  1  one-cycle pulse in the cycle the swap occurs.
- frame_start  in  1  pulse from scan driver at start of row 0.
- rd_en  in  1  read strobe from scan driver.
- rd_row  in  $clog2(ROWS)  row to read from front buffer.
- rd_data  out  COLS  front-buffer row data, registered.

Behaviour:
- One clock; reset is synchronous and active-high on rst, sampled at the rising edge of clk.
- Reset values: both buffers all-zero, front_sel=0, state IDLE, wr_ready=0 during reset and 1 from the first cycle after, swap_ack=0, rd_data=0.
- Write:
  - A transfer occurs when wr_valid && wr_ready at the edge.
  - The back buffer row is updated at that edge.
  - wr_row >= ROWS: the beat is accepted and the data is dropped.
- Read latency is 1:
  - rd_en at edge N gives front[rd_row] on rd_data after edge N.
  - rd_data holds its value when rd_en=0.
  - rd_row >= ROWS returns 0.
- FSM IDLE -> PENDING -> IDLE:
  - IDLE: wr_ready=1. swap_req=1 goes to PENDING. A write in the same cycle is still accepted.
  - PENDING: wr_ready=0, freezing the back buffer. Further swap_req is ignored. frame_start=1 toggles front_sel, pulses swap_ack for one cycle and returns to IDLE.
  - A frame_start in the same cycle as the swap_req that enters PENDING does not swap; the swap waits for the next frame_start.
- Read during the swap cycle: a read sampled in that cycle uses the old front_sel. The first read after the edge sees the new front.
- CLEAR_ON_SWAP=1: the new back buffer (old front) is zeroed at the swap edge. It reads as zeros once writes resume.
- Reset mid-PENDING: the swap is abandoned, buffers are cleared and no swap_ack is issued.

Optional Feature:
- Macro: MAT_FB_SCROLL_EN.
- With the macro:
  - A frame counter counts frame_start pulses. Every SCROLL_DIV frames a column offset (0..COLS-1, wraps) increments.
  - rd_data = front row rotated left by the offset.
  - The offset resets to 0 on rst and on every swap.
- Without the macro: no counter or offset logic; rd_data is the unrotated row and SCROLL_DIV is unused. Ports are identical in both builds.

Decomposition:
- Shared package mat_pkg:
  - MAT_ROWS=8, MAT_COLS=8, and row_idx_t / row_data_t typedefs.
  - fb_state_t enum {FB_IDLE, FB_PENDING}, shared with the scan driver and its bench.
- One natural sub-module, mat_fb_bank: a ROWS x COLS register array with a sync write port, a clear input and a combinational read. It is instantiated twice. The top holds the FSM, front_sel, the read register and the optional scroll logic.

Test Plan:
- Reset release: rst high 2 cycles then low -> wr_ready=1 next cycle; rd_en rows 0..7 all return 8'h00; swap_ack=0.
- Write and swap:
  - Write row3=8'hA5, row7=8'h81, then swap_req; frame_start 5 cycles later -> swap_ack pulses exactly in that cycle; wr_ready=0 in between.
  - Reads of row 3 give 8'hA5 and row 7 gives 8'h81, 1 cycle after rd_en.
- No tearing: after the swap, write row3=8'hFF and do not swap -> rd_row=3 still returns 8'hA5 across 3 frame_start pulses.
- Simultaneous: swap_req and frame_start in the same cycle in IDLE -> no swap_ack that cycle; the swap happens at the following frame_start.
- Boundary: wr_row/rd_row out of range is not possible at ROWS=8; set ROWS=6 and write row 7 -> no bank changes and rd_row=7 returns 0. A reset asserted while PENDING -> no swap_ack and all rows read 0.
- With MAT_FB_SCROLL_EN and SCROLL_DIV=2, front row0=8'h01 -> after 2 frame_start pulses reads 8'h02, after 16 pulses reads 8'h01 again (wrap); after a swap the offset returns to 0.
